// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle processor control path:
// FSM state codes, opcode values, ALU/branch select encodings and the strobe bundle.
package cpu_ctrl_pkg;

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_F0     = 4'd1;
    localparam logic [3:0] S_F1     = 4'd2;
    localparam logic [3:0] S_DEC    = 4'd3;
    localparam logic [3:0] S_R_EX   = 4'd4;
    localparam logic [3:0] S_I_EX   = 4'd5;
    localparam logic [3:0] S_WB_ALU = 4'd6;
    localparam logic [3:0] S_M_ADDR = 4'd7;
    localparam logic [3:0] S_LD0    = 4'd8;
    localparam logic [3:0] S_LD1    = 4'd9;
    localparam logic [3:0] S_WB_MEM = 4'd10;
    localparam logic [3:0] S_ST     = 4'd11;
    localparam logic [3:0] S_BR     = 4'd12;
    localparam logic [3:0] S_J      = 4'd13;
    localparam logic [3:0] S_HALT   = 4'd14;

    localparam logic [6:0] OP_ADD  = 7'h00;
    localparam logic [6:0] OP_SUB  = 7'h01;
    localparam logic [6:0] OP_AND  = 7'h02;
    localparam logic [6:0] OP_OR   = 7'h03;
    localparam logic [6:0] OP_ADDI = 7'h10;
    localparam logic [6:0] OP_LW   = 7'h20;
    localparam logic [6:0] OP_SW   = 7'h21;
    localparam logic [6:0] OP_BEQ  = 7'h30;
    localparam logic [6:0] OP_BNE  = 7'h31;
    localparam logic [6:0] OP_BLT  = 7'h32;
    localparam logic [6:0] OP_J    = 7'h40;
    localparam logic [6:0] OP_HALT = 7'h7F;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] BT_EQ = 2'b00;
    localparam logic [1:0] BT_NE = 2'b01;
    localparam logic [1:0] BT_LT = 2'b10;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_HALT, CLS_ILL
    } op_class_e;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_write;
        logic       isbranch;
        logic [1:0] branch_type;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier: maps the IR control field to an instruction
// class and flags every undefined encoding (including reserved branch type 11).
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW = 7
) (
    input  logic [OPW-1:0] opcode,
    output op_class_e      op_class,
    output logic           illegal
);

    // Opcode to class lookup; anything not listed is illegal.
    always_comb begin
        op_class = CLS_ILL;
        illegal  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_R;
            OP_ADDI:                       op_class = CLS_I;
            OP_LW:                         op_class = CLS_LW;
            OP_SW:                         op_class = CLS_SW;
            OP_BEQ, OP_BNE, OP_BLT:        op_class = CLS_BR;
            OP_J:                          op_class = CLS_J;
            OP_HALT:                       op_class = CLS_HALT;
            default: begin
                op_class = CLS_ILL;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 16-bit multi-cycle CPU. Strobes are registered from the
// next state so they are Moore outputs of the current state and clear at once on reset.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 7,
    parameter int CNTW = 16
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [OPW-1:0]  input_opcode,
    input  logic            input_run,
    output logic            output_PCWrite,
    output logic            output_IR_write,
    output logic            output_IorD,
    output logic            output_mem_write,
    output logic            output_isbranch,
    output logic [1:0]      output_branchType,
    output logic            output_ALUSrcA,
    output logic [1:0]      output_ALUSrcB,
    output logic [1:0]      output_ALUOp,
    output logic            output_RegWrite,
    output logic            output_MemToReg,
    output logic            output_halted,
    output logic            output_illegal,
    output logic [CNTW-1:0] output_instr_count
);

    logic [3:0]      state_q, state_d;
    logic            illegal_q, illegal_d;
    logic            halted_q, halted_d;
    logic [CNTW-1:0] count_q, count_d;
    ctrl_t           ctrl_q, ctrl_d;
    op_class_e       op_class_s;
    logic            dec_illegal_s;
    logic            retire_s;

    ctrl_decode #(.OPW(OPW)) u_decode (
        .opcode   (input_opcode),
        .op_class (op_class_s),
        .illegal  (dec_illegal_s)
    );

    // Next-state, retire and sticky-illegal logic.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        retire_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (input_run) state_d = S_F0;
                else           state_d = S_IDLE;
            end
            S_F0: state_d = S_F1;
            S_F1: state_d = S_DEC;
            S_DEC: begin
                if (dec_illegal_s) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    case (op_class_s)
                        CLS_R:          state_d = S_R_EX;
                        CLS_I:          state_d = S_I_EX;
                        CLS_LW, CLS_SW: state_d = S_M_ADDR;
                        CLS_BR:         state_d = S_BR;
                        CLS_J:          state_d = S_J;
                        CLS_HALT: begin
                            state_d  = S_HALT;
                            retire_s = 1'b1;
                        end
                        default: begin
                            state_d   = S_HALT;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_R_EX, S_I_EX: state_d = S_WB_ALU;
            S_M_ADDR: begin
                if (op_class_s == CLS_LW) state_d = S_LD0;
                else                      state_d = S_ST;
            end
            S_LD0: state_d = S_LD1;
            S_LD1: state_d = S_WB_MEM;
            S_WB_ALU, S_WB_MEM, S_ST, S_BR, S_J: begin
                state_d  = S_F0;
                retire_s = 1'b1;
            end
            S_HALT: begin
                if (input_run) begin
                    state_d   = S_F0;
                    illegal_d = 1'b0;
                end else begin
                    state_d   = S_HALT;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (retire_s) count_d = count_q + {{(CNTW-1){1'b0}}, 1'b1};
        else          count_d = count_q;
    end

    // Strobe decode of the state being entered; opcode is stable once IR is loaded.
    always_comb begin
        ctrl_d   = '0;
        halted_d = (state_d == S_HALT);
        case (state_d)
            S_F1: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.alu_src_b = SRCB_ONE;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_R_EX: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_REGB;
                ctrl_d.alu_op    = input_opcode[1:0];
            end
            S_I_EX, S_M_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            S_WB_ALU: ctrl_d.reg_write = 1'b1;
            S_LD0, S_LD1: ctrl_d.iord = 1'b1;
            S_WB_MEM: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_ST: begin
                ctrl_d.iord      = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            S_BR: begin
                ctrl_d.alu_src_a   = 1'b1;
                ctrl_d.alu_src_b   = SRCB_REGB;
                ctrl_d.alu_op      = ALU_SUB;
                ctrl_d.isbranch    = 1'b1;
                ctrl_d.branch_type = input_opcode[1:0];
            end
            S_J: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            default: ctrl_d = '0;
        endcase
    end

    // State, status and strobe registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            halted_q  <= halted_d;
            count_q   <= count_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign output_PCWrite     = ctrl_q.pc_write;
    assign output_IR_write    = ctrl_q.ir_write;
    assign output_IorD        = ctrl_q.iord;
    assign output_mem_write   = ctrl_q.mem_write;
    assign output_isbranch    = ctrl_q.isbranch;
    assign output_branchType  = ctrl_q.branch_type;
    assign output_ALUSrcA     = ctrl_q.alu_src_a;
    assign output_ALUSrcB     = ctrl_q.alu_src_b;
    assign output_ALUOp       = ctrl_q.alu_op;
    assign output_RegWrite    = ctrl_q.reg_write;
    assign output_MemToReg    = ctrl_q.mem_to_reg;
    assign output_halted      = halted_q;
    assign output_illegal     = illegal_q;
    assign output_instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class cycle by
// cycle and compares the whole strobe vector against hand-built expectations.
module tb_multicycle_control;

    logic        CLK;
    logic        RST_N;
    logic [6:0]  input_opcode;
    logic        input_run;
    logic        output_PCWrite, output_IR_write, output_IorD, output_mem_write;
    logic        output_isbranch, output_ALUSrcA, output_RegWrite, output_MemToReg;
    logic        output_halted, output_illegal;
    logic [1:0]  output_branchType, output_ALUSrcB, output_ALUOp;
    logic [15:0] output_instr_count;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.OPW(7), .CNTW(16)) dut (
        .CLK                (CLK),
        .RST_N              (RST_N),
        .input_opcode       (input_opcode),
        .input_run          (input_run),
        .output_PCWrite     (output_PCWrite),
        .output_IR_write    (output_IR_write),
        .output_IorD        (output_IorD),
        .output_mem_write   (output_mem_write),
        .output_isbranch    (output_isbranch),
        .output_branchType  (output_branchType),
        .output_ALUSrcA     (output_ALUSrcA),
        .output_ALUSrcB     (output_ALUSrcB),
        .output_ALUOp       (output_ALUOp),
        .output_RegWrite    (output_RegWrite),
        .output_MemToReg    (output_MemToReg),
        .output_halted      (output_halted),
        .output_illegal     (output_illegal),
        .output_instr_count (output_instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [15:0] obs_vec;
    assign obs_vec = {output_PCWrite, output_IR_write, output_IorD, output_mem_write,
                      output_isbranch, output_branchType, output_ALUSrcA, output_ALUSrcB,
                      output_ALUOp, output_RegWrite, output_MemToReg, output_halted,
                      output_illegal};

    // Packs expected strobes in the same order as obs_vec.
    function automatic logic [15:0] sv(input logic pcw, input logic irw, input logic iord,
                                       input logic mw, input logic isb, input logic [1:0] bt,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] op,
                                       input logic rw, input logic m2r, input logic h,
                                       input logic il);
        return {pcw, irw, iord, mw, isb, bt, sa, sb, op, rw, m2r, h, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // F1 then DEC, common to every instruction.
    task automatic front(input string name);
        tick(); chk({name, "_F1"},  {16'h0, obs_vec},
                    {16'h0, sv(1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk({name, "_DEC"}, {16'h0, obs_vec}, 32'h0);
    endtask

    initial begin
        RST_N = 1'b0; input_run = 1'b0; input_opcode = 7'h00;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_vec", {16'h0, obs_vec}, 32'h0);
        chk("reset_cnt", {16'h0, output_instr_count}, 32'h0);
        RST_N = 1'b1;
        tick(); chk("idle_wait", {16'h0, obs_vec}, 32'h0);

        // ADD: F0/F1/DEC/R_EX/WB_ALU
        input_run = 1'b1; input_opcode = 7'h00;
        tick(); chk("add_F0", {16'h0, obs_vec}, 32'h0);
        front("add");
        tick(); chk("add_REX", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("add_WB", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0)});
        tick(); chk("add_back_F0", {16'h0, obs_vec}, 32'h0);
        chk("add_cnt", {16'h0, output_instr_count}, 32'd1);

        // OR: ALUOp follows opcode[1:0]
        input_opcode = 7'h03;
        front("or");
        tick(); chk("or_REX", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,2'b11,1'b0,1'b0,1'b0,1'b0)});
        tick(); tick(); chk("or_cnt", {16'h0, output_instr_count}, 32'd2);

        // ADDI
        input_opcode = 7'h10;
        front("addi");
        tick(); chk("addi_IEX", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("addi_WB", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0)});
        tick(); chk("addi_cnt", {16'h0, output_instr_count}, 32'd3);

        // LW: 7 cycles, IorD held through LD0/LD1
        input_opcode = 7'h20;
        front("lw");
        tick(); chk("lw_MADDR", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("lw_LD0", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("lw_LD1", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("lw_WBMEM", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b1,1'b1,1'b0,1'b0)});
        tick(); chk("lw_F0", {16'h0, obs_vec}, 32'h0);
        chk("lw_cnt", {16'h0, output_instr_count}, 32'd4);

        // SW: single-cycle write with IorD
        input_opcode = 7'h21;
        front("sw");
        tick(); chk("sw_MADDR", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("sw_ST", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("sw_F0", {16'h0, obs_vec}, 32'h0);
        chk("sw_cnt", {16'h0, output_instr_count}, 32'd5);

        // BNE: compare cycle, no PCWrite
        input_opcode = 7'h31;
        front("bne");
        tick(); chk("bne_BR", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,2'b01,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("bne_F0", {16'h0, obs_vec}, 32'h0);
        chk("bne_cnt", {16'h0, output_instr_count}, 32'd6);

        // J: PC + imm
        input_opcode = 7'h40;
        front("j");
        tick(); chk("j_J", {16'h0, obs_vec},
                    {16'h0, sv(1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0)});
        tick(); chk("j_cnt", {16'h0, output_instr_count}, 32'd7);

        // Undefined 55: HALT + illegal, no retire; run restarts and clears illegal
        input_opcode = 7'h55; input_run = 1'b0;
        front("ill");
        tick(); chk("ill_HALT", {16'h0, obs_vec},
                    {16'h0, sv(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b1)});
        tick(); chk("ill_hold", {16'h0, obs_vec}, 32'h3);
        chk("ill_cnt", {16'h0, output_instr_count}, 32'd7);
        input_run = 1'b1;
        tick(); chk("ill_restart", {16'h0, obs_vec}, 32'h0);

        // Reserved branch type 33 is illegal too
        input_opcode = 7'h33; input_run = 1'b0;
        front("b33");
        tick(); chk("b33_HALT", {16'h0, obs_vec}, 32'h3);
        input_run = 1'b1;
        tick();

        // 7F: retires into HALT, not illegal
        input_opcode = 7'h7F; input_run = 1'b0;
        front("hlt");
        tick(); chk("hlt_HALT", {16'h0, obs_vec}, 32'h2);
        chk("hlt_cnt", {16'h0, output_instr_count}, 32'd8);
        input_run = 1'b1;
        tick(); chk("hlt_restart", {16'h0, obs_vec}, 32'h0);

        // Reset during LD1 clears everything at once
        input_opcode = 7'h20;
        front("lwr");
        tick(); tick(); tick();
        chk("lwr_LD1", {16'h0, obs_vec},
            {16'h0, sv(1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0)});
        RST_N = 1'b0;
        #1;
        chk("rst_mid_vec", {16'h0, obs_vec}, 32'h0);
        chk("rst_mid_cnt", {16'h0, output_instr_count}, 32'h0);
        input_run = 1'b0;
        tick();
        RST_N = 1'b1;
        tick(); tick(); chk("rst_idle", {16'h0, obs_vec}, 32'h0);

        // Counter wrap: preload FFFF while idle, then retire one J
        force dut.count_q = 16'hFFFF;
        tick();
        release dut.count_q;
        tick(); chk("pre_cnt", {16'h0, output_instr_count}, 32'h0000FFFF);
        input_opcode = 7'h40; input_run = 1'b1;
        tick(); chk("wrap_F0", {16'h0, obs_vec}, 32'h0);
        front("wrap");
        tick(); tick(); chk("wrap_cnt", {16'h0, output_instr_count}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM of the 16-bit multi-cycle processor. It sits directly downstream of the fetch/memory stage, decoding the 7-bit IR control field and sequencing every datapath strobe, including PC write, IR write, IorD, memory write, branch compare and register write. It also keeps a retired-instruction counter and a halt/illegal status for the bench and debug.

Parameters:
OPW, 7, opcode field width (IR control field)
CNTW, 16, retired-instruction counter width

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
input_opcode  input  OPW  IR control field, stable after IR write
input_run  input  1  1 = leave IDLE/HALT and start fetching
output_PCWrite  output  1  PC update strobe
output_IR_write  output  1  IR load strobe
output_IorD  output  1  0 = memory address from PC, 1 = from ALUOut
output_mem_write  output  1  memory write strobe
output_isbranch  output  1  PC performs conditional compare this cycle
output_branchType  output  2  00 = eq, 01 = ne, 10 = lt
output_ALUSrcA  output  1  0 = PC, 1 = regA
output_ALUSrcB  output  2  00 = regB, 01 = const 1, 10 = imm
output_ALUOp  output  2  00 = add, 01 = sub, 10 = and, 11 = or
output_RegWrite  output  1  register file write strobe
output_MemToReg  output  1  write-back source: 0 = ALUOut, 1 = MDR
output_halted  output  1  FSM is in HALT
output_illegal  output  1  sticky; undefined opcode was decoded
output_instr_count  output  CNTW  retired instructions

Behaviour:
- Reset (async, RST_N low): state = IDLE; all strobes 0; ALU selects 0; halted = 0; illegal = 0; count = 0. Reset mid-instruction aborts it with no partial write.
- All strobes are Moore outputs decoded from state only. Any strobe not listed for a state is 0.
- Memory read is synchronous: q is valid 1 cycle after the address. MDR adds 1 more cycle.
- IDLE: waits for input_run = 1, then goes to F0.
- F0: IorD = 0. Goes to F1.
- F1: IR_write = 1; ALUSrcA = 0, ALUSrcB = 01, ALUOp = add; PCWrite = 1 (PC+1). Goes to DEC.
- DEC: decodes opcode. Goes to R_EX, I_EX, M_ADDR, BR, J or HALT.
- R_EX (ADD 00, SUB 01, AND 02, OR 03): ALUSrcA = 1, ALUSrcB = 00, ALUOp = opcode[1:0]. Goes to WB_ALU.
- I_EX (ADDI 10): ALUSrcA = 1, ALUSrcB = 10, ALUOp = add. Goes to WB_ALU.
- WB_ALU: RegWrite = 1, MemToReg = 0. Retires. Goes to F0.
- M_ADDR (LW 20, SW 21): ALUSrcA = 1, ALUSrcB = 10, ALUOp = add. LW goes to LD0; SW goes to ST.
- LD0: IorD = 1. Goes to LD1.
- LD1: IorD = 1 held. Goes to WB_MEM.
- WB_MEM: RegWrite = 1, MemToReg = 1. Retires. Goes to F0.
- ST: IorD = 1, mem_write = 1 for exactly 1 cycle. Retires. Goes to F0.
- BR (BEQ 30, BNE 31, BLT 32): ALUSrcA = 1, ALUSrcB = 00, ALUOp = sub; isbranch = 1; branchType = opcode[1:0]. PCWrite = 0; the PC module resolves taken/not-taken. Retires. Goes to F0.
- J (40): PCWrite = 1 with ALUSrcA = 0, ALUSrcB = 10, ALUOp = add (PC+imm). Retires. Goes to F0.
- HALT: opcode 7F retires and goes to HALT. Any undefined opcode goes to HALT, sets illegal and does not retire.
- In HALT, halted = 1. input_run = 1 restarts at F0 and clears illegal.
- Counter: increments on each retiring state and wraps FFFF to 0000.
- Opcodes 33 (reserved branch type 11) and all other undefined values are illegal.
- CPI: R/I = 5, LW = 7, SW = 5, BR = 4, J = 4 (F0, F1, DEC included).

Decomposition:
- Package cpu_ctrl_pkg holds the state enum, all opcode constants, and the ALUOp, ALUSrcB and branchType encodings.
- One sub-module, ctrl_decode: combinational opcode to {class, illegal}, so decode can be tested on its own.
- The FSM and counter stay in multicycle_control.

Test Plan:
1. Reset, then run = 1, opcode = 00 (ADD) → strobe trace F0/F1/DEC/R_EX/WB_ALU. IR_write and PCWrite high in cycle 2 only. RegWrite high in cycle 5. Count = 1.
2. LW (20) → IorD high in LD0 and LD1. RegWrite with MemToReg = 1 in cycle 7. mem_write never asserted.
3. SW (21) → mem_write high for exactly 1 cycle, with IorD = 1. RegWrite stays 0.
4. BNE (31) → isbranch = 1, branchType = 01, ALUOp = sub for 1 cycle. PCWrite = 0 in that cycle. Back to F0 next.
5. Opcode 55 → HALT, illegal = 1, count unchanged. Then run = 1 → F0 and illegal = 0.
6. RST_N low during LD1 → all outputs 0 immediately, state IDLE. Preload count to FFFF and retire once → count = 0000.
